// File: rtl/m_fwd_producer_reg_pkg.sv
// Shared encodings and widths for the forwarding producers and consumers.
// Also holds the Tnew ageing rule used by the pipeline registers.
package m_fwd_producer_reg_pkg;

  localparam int TNEW_W = 2;
  localparam int REG_W  = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] WD_ALU  = 3'b000;
  localparam logic [OP_W-1:0] WD_DM   = 3'b001;
  localparam logic [OP_W-1:0] WD_LINK = 3'b010;

  // One stage closer to ready, saturating at zero.
  function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] tnew);
    logic [TNEW_W-1:0] aged;
    if (tnew == {TNEW_W{1'b0}}) begin
      aged = {TNEW_W{1'b0}};
    end else begin
      aged = tnew - TNEW_W'(1);
    end
    return aged;
  endfunction

endpackage

// File: rtl/m_fwd_producer_reg_fwd_src_sel.sv
// Forward value and validity derived from a producer stage's registered fields.
// Stage-agnostic, so the W-stage producer register can reuse it.
module m_fwd_producer_reg_fwd_src_sel
  import m_fwd_producer_reg_pkg::*;
#(
  parameter int DW       = 32,
  parameter int LINK_OFS = 8
) (
  input  logic [DW-1:0]     pc_i,
  input  logic [DW-1:0]     alu_i,
  input  logic [REG_W-1:0]  a3_i,
  input  logic              regwrite_i,
  input  logic [TNEW_W-1:0] tnew_i,
  input  logic [OP_W-1:0]   grfwdop_i,
  output logic [DW-1:0]     fwd_data_o,
  output logic              fwd_valid_o
);

  // Link writes are ready as soon as PC is known; $0 is never forwarded.
  always_comb begin
    fwd_data_o  = alu_i;
    fwd_valid_o = 1'b0;
    if (grfwdop_i == WD_LINK) begin
      fwd_data_o = pc_i + DW'(LINK_OFS);
    end else begin
      fwd_data_o = alu_i;
    end
    fwd_valid_o = regwrite_i && (a3_i != {REG_W{1'b0}}) &&
                  ((tnew_i == {TNEW_W{1'b0}}) || (grfwdop_i == WD_LINK));
  end

endmodule

// File: rtl/m_fwd_producer_reg.sv
// E/M pipeline register with the M-stage forwarding-producer outputs.
// flush inserts a bubble (all zero) and overrides en; en=0 freezes the stage, Tnew included.
module m_fwd_producer_reg
  import m_fwd_producer_reg_pkg::*;
#(
  parameter int DW       = 32,
  parameter int LINK_OFS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [DW-1:0]     E_PC,
  input  logic [DW-1:0]     E_ALUout,
  input  logic [DW-1:0]     E_RTdata,
  input  logic [REG_W-1:0]  E_A3,
  input  logic              E_RegWrite,
  input  logic [TNEW_W-1:0] E_Tnew,
  input  logic [OP_W-1:0]   E_GRFWDop,
  output logic [DW-1:0]     M_PC,
  output logic [DW-1:0]     M_ALUout,
  output logic [DW-1:0]     M_RTdata,
  output logic [REG_W-1:0]  M_A3,
  output logic              M_RegWrite,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic [OP_W-1:0]   M_GRFWDop,
  output logic [DW-1:0]     M_fwd_data,
  output logic              M_fwd_valid
);

  logic [DW-1:0]     pc_q,  pc_d;
  logic [DW-1:0]     alu_q, alu_d;
  logic [DW-1:0]     rt_q,  rt_d;
  logic [REG_W-1:0]  a3_q,  a3_d;
  logic              rw_q,  rw_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [OP_W-1:0]   op_q,  op_d;

  // Next-state selection: flush beats en, otherwise hold.
  always_comb begin
    pc_d   = pc_q;
    alu_d  = alu_q;
    rt_d   = rt_q;
    a3_d   = a3_q;
    rw_d   = rw_q;
    tnew_d = tnew_q;
    op_d   = op_q;
    if (flush) begin
      pc_d   = {DW{1'b0}};
      alu_d  = {DW{1'b0}};
      rt_d   = {DW{1'b0}};
      a3_d   = {REG_W{1'b0}};
      rw_d   = 1'b0;
      tnew_d = {TNEW_W{1'b0}};
      op_d   = WD_ALU;
    end else if (en) begin
      pc_d   = E_PC;
      alu_d  = E_ALUout;
      rt_d   = E_RTdata;
      a3_d   = E_A3;
      rw_d   = E_RegWrite;
      tnew_d = tnew_age(E_Tnew);
      op_d   = E_GRFWDop;
    end else begin
      tnew_d = tnew_q;
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= {DW{1'b0}};
      alu_q  <= {DW{1'b0}};
      rt_q   <= {DW{1'b0}};
      a3_q   <= {REG_W{1'b0}};
      rw_q   <= 1'b0;
      tnew_q <= {TNEW_W{1'b0}};
      op_q   <= WD_ALU;
    end else begin
      pc_q   <= pc_d;
      alu_q  <= alu_d;
      rt_q   <= rt_d;
      a3_q   <= a3_d;
      rw_q   <= rw_d;
      tnew_q <= tnew_d;
      op_q   <= op_d;
    end
  end

  assign M_PC       = pc_q;
  assign M_ALUout   = alu_q;
  assign M_RTdata   = rt_q;
  assign M_A3       = a3_q;
  assign M_RegWrite = rw_q;
  assign M_Tnew     = tnew_q;
  assign M_GRFWDop  = op_q;

  m_fwd_producer_reg_fwd_src_sel #(
    .DW       (DW),
    .LINK_OFS (LINK_OFS)
  ) u_fwd_src_sel (
    .pc_i        (pc_q),
    .alu_i       (alu_q),
    .a3_i        (a3_q),
    .regwrite_i  (rw_q),
    .tnew_i      (tnew_q),
    .grfwdop_i   (op_q),
    .fwd_data_o  (M_fwd_data),
    .fwd_valid_o (M_fwd_valid)
  );

endmodule

// File: tb/tb_m_fwd_producer_reg.sv
// Self-checking bench for m_fwd_producer_reg: directed cases plus randomized traffic
// compared against a field-level reference model of the E/M stage.
module tb_m_fwd_producer_reg;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [31:0] E_PC, E_ALUout, E_RTdata;
  logic [4:0]  E_A3;
  logic        E_RegWrite;
  logic [1:0]  E_Tnew;
  logic [2:0]  E_GRFWDop;
  logic [31:0] M_PC, M_ALUout, M_RTdata, M_fwd_data;
  logic [4:0]  M_A3;
  logic        M_RegWrite, M_fwd_valid;
  logic [1:0]  M_Tnew;
  logic [2:0]  M_GRFWDop;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: what the M stage should hold
  longint r_pc, r_alu, r_rt, r_a3, r_rw, r_tnew, r_op;

  always #5 clk = ~clk;

  m_fwd_producer_reg #(.DW(32), .LINK_OFS(8)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .E_PC(E_PC), .E_ALUout(E_ALUout), .E_RTdata(E_RTdata), .E_A3(E_A3),
    .E_RegWrite(E_RegWrite), .E_Tnew(E_Tnew), .E_GRFWDop(E_GRFWDop),
    .M_PC(M_PC), .M_ALUout(M_ALUout), .M_RTdata(M_RTdata), .M_A3(M_A3),
    .M_RegWrite(M_RegWrite), .M_Tnew(M_Tnew), .M_GRFWDop(M_GRFWDop),
    .M_fwd_data(M_fwd_data), .M_fwd_valid(M_fwd_valid)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    r_pc = 0; r_alu = 0; r_rt = 0; r_a3 = 0; r_rw = 0; r_tnew = 0; r_op = 0;
  endtask

  task automatic check_all(input string tag);
    longint fd, fv;
    fd = (r_op == 2) ? ((r_pc + 8) % 64'h1_0000_0000) : r_alu;
    fv = (r_rw == 1 && r_a3 != 0 && (r_tnew == 0 || r_op == 2)) ? 1 : 0;
    chk({tag, ".pc"},   M_PC,        r_pc);
    chk({tag, ".alu"},  M_ALUout,    r_alu);
    chk({tag, ".rt"},   M_RTdata,    r_rt);
    chk({tag, ".a3"},   M_A3,        r_a3);
    chk({tag, ".rw"},   M_RegWrite,  r_rw);
    chk({tag, ".tnew"}, M_Tnew,      r_tnew);
    chk({tag, ".op"},   M_GRFWDop,   r_op);
    chk({tag, ".fwdd"}, M_fwd_data,  fd);
    chk({tag, ".fwdv"}, M_fwd_valid, fv);
  endtask

  // clock edge, update the model from the inputs present at the edge, then check
  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) model_clear();
    else if (flush) model_clear();
    else if (en) begin
      r_pc = E_PC; r_alu = E_ALUout; r_rt = E_RTdata; r_a3 = E_A3;
      r_rw = E_RegWrite; r_op = E_GRFWDop;
      r_tnew = (E_Tnew > 0) ? E_Tnew - 1 : 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] a3,
                       input logic rw, input logic [1:0] tn, input logic [2:0] op,
                       input logic e, input logic f);
    E_PC = pc; E_ALUout = alu; E_RTdata = $urandom; E_A3 = a3;
    E_RegWrite = rw; E_Tnew = tn; E_GRFWDop = op; en = e; flush = f;
  endtask

  task automatic drive_rand();
    E_PC = $urandom; E_ALUout = $urandom; E_RTdata = $urandom;
    E_A3 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    E_RegWrite = 1'($urandom); E_Tnew = 2'($urandom);
    E_GRFWDop = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
    en = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    model_clear();
    reset = 1'b0;
    drive(32'hDEAD_BEEF, 32'h1111_2222, 5'd7, 1'b1, 2'd1, 3'b010, 1'b1, 1'b0);
    #1;
    check_all("rst_async");
    step("rst_hold0");
    step("rst_hold1");
    #2 reset = 1'b1;
    drive(32'h0000_1000, 32'h0000_1234, 5'd5, 1'b1, 2'd1, 3'b000, 1'b1, 1'b0);
    step("alu");
    chk("alu_tnew", M_Tnew, 0);
    chk("alu_data", M_fwd_data, 32'h0000_1234);
    chk("alu_valid", M_fwd_valid, 1);

    drive(32'h0000_1004, 32'h0000_0040, 5'd8, 1'b1, 2'd2, 3'b001, 1'b1, 1'b0);
    step("load");
    chk("load_tnew", M_Tnew, 1);
    chk("load_valid", M_fwd_valid, 0);
    drive(32'h0000_1008, 32'h0000_0044, 5'd8, 1'b1, 2'd0, 3'b001, 1'b1, 1'b0);
    step("load_sat");
    chk("load_sat_tnew", M_Tnew, 0);
    chk("load_sat_valid", M_fwd_valid, 1);
    drive(32'h0000_100C, 32'h0000_0048, 5'd3, 1'b1, 2'd3, 3'b000, 1'b1, 1'b0);
    step("tnew3");
    chk("tnew3_tnew", M_Tnew, 2);

    drive(32'h0000_3000, 32'h5555_5555, 5'd31, 1'b1, 2'd2, 3'b010, 1'b1, 1'b0);
    step("link");
    chk("link_data", M_fwd_data, 32'h0000_3008);
    chk("link_valid", M_fwd_valid, 1);
    drive(32'hFFFF_FFFC, 32'h5555_5555, 5'd31, 1'b1, 2'd2, 3'b010, 1'b1, 1'b0);
    step("link_wrap");
    chk("link_wrap_data", M_fwd_data, 32'h0000_0004);

    drive(32'h0000_2000, 32'h0000_0999, 5'd9, 1'b1, 2'd3, 3'b000, 1'b1, 1'b0);
    step("hold_cap");
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      en = 1'b0; flush = 1'b0;
      step("hold");
      chk("hold_a3", M_A3, 9);
      chk("hold_tnew", M_Tnew, 2);
    end
    drive(32'h0000_2004, 32'h0000_0777, 5'd10, 1'b1, 2'd0, 3'b000, 1'b1, 1'b1);
    step("flush");
    chk("flush_pc", M_PC, 0);
    chk("flush_valid", M_fwd_valid, 0);

    drive(32'h0000_2008, 32'h0000_0ABC, 5'd0, 1'b1, 2'd0, 3'b000, 1'b1, 1'b0);
    step("zero_reg");
    chk("zero_reg_rw", M_RegWrite, 1);
    chk("zero_reg_valid", M_fwd_valid, 0);

    for (int i = 0; i < 400; i++) begin
      drive_rand();
      if (i == 200) begin
        drive(32'h0000_4000, 32'h0000_0123, 5'd4, 1'b1, 2'd1, 3'b000, 1'b1, 1'b0);
        step("pre_midrst");
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all("midrst");
        #1 reset = 1'b1;
        drive_rand();
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
